hazard_controller: RTL
======================

// Module: hazard_controller
// PURPOSE
//  Pipeline sequencer for the 5-stage RV32i core. Drives stall/flush enables of the IF/ID, ID/EX and
//  EX/MEM pipeline registers, and the EX-stage forwarding selects. Handles load-use bubbles,
//  branch/jump redirect flushes and multi-cycle data-memory waits (MEM_WAIT FSM with timeout).
//  Keeps saturating stall/flush event counters for performance debug.
// PARAMETERS
//  CNT_W        16   width of Stall_Cycles / Flush_Count performance counters (saturating)
//  MEM_TIMEOUT  255  max consecutive D_MEM_Busy cycles before entering ERROR (>=1)
// PORTS
//  CLK              in   1  core clock, all state on posedge
//  RST_N            in   1  synchronous reset, active-low
//  RS1_D, RS2_D     in   5  source regs of instruction in decode
//  RS1_E, RS2_E     in   5  source regs of instruction in execute
//  RD_E, RD_M, RD_W in   5  destination regs in execute / memory / writeback
//  REG_W_En_E/M/W   in   1  register write enable per stage
//  Result_Src_Sel_E in   2  result select in execute; 2'b01 = load data
//  Mispredict_E     in   1  execute resolved redirect (wrong prediction or jump)
//  D_MEM_Busy       in   1  data memory not ready; access in MEM must be held
//  Stall_F, Stall_D out  1  hold PC / IF/ID register
//  Stall_E, Stall_M out  1  hold ID/EX / EX/MEM register
//  Flush_D, Flush_E out  1  insert NOP into IF/ID / ID/EX register
//  Forward_A_E      out  2  ALU operand A source: 00 regfile, 01 writeback result, 10 MEM ALU result
//  Forward_B_E      out  2  same encoding, operand B
//  Mem_Timeout      out  1  sticky: FSM in ERROR
//  Stall_Cycles     out  CNT_W  cycles with Stall_F asserted, saturates at all-ones
//  Flush_Count      out  CNT_W  cycles with Flush_E asserted, saturates at all-ones
// BEHAVIOUR
//  FSM states: RUN, MEM_WAIT, ERROR. Reset (RST_N=0 at posedge): state=RUN, wait counter=0,
//   Stall_Cycles=0, Flush_Count=0, Mem_Timeout=0. While RST_N=0 all stalls=0, Flush_D=Flush_E=1.
//  Forwarding (combinational, zero latency): A: RS1_E!=0 & REG_W_En_M & RD_M==RS1_E -> 10;
//   else RS1_E!=0 & REG_W_En_W & RD_W==RS1_E -> 01; else 00. B identical with RS2_E. MEM beats WB.
//  Load-use (combinational): LU = REG_W_En_E & Result_Src_Sel_E==2'b01 & RD_E!=0 &
//   (RD_E==RS1_D | RD_E==RS2_D). Effect: Stall_F=Stall_D=1, Flush_E=1 for one cycle (one bubble).
//  Redirect: Mispredict_E -> Flush_D=Flush_E=1; Stall_F=Stall_D=0 (LU suppressed, PC takes target).
//  Memory wait: D_MEM_Busy=1 -> Stall_F/D/E/M=1, Flush_D=Flush_E=0 (overrides LU and Mispredict;
//   both are re-evaluated on the first cycle busy is low, as E/D contents are held).
//  Transitions: RUN->MEM_WAIT when D_MEM_Busy; wait counter loads 1.
//   MEM_WAIT: busy -> counter+1; counter==MEM_TIMEOUT with busy still high -> ERROR; busy low -> RUN, counter=0.
//   ERROR: absorbing until reset; Stall_F/D/E/M=1, flushes 0, Mem_Timeout=1.
//  Stall outputs follow D_MEM_Busy combinationally in RUN/MEM_WAIT (release in same cycle busy drops).
//  Counters: increment on posedge when respective output is 1 and RST_N=1; hold at 2^CNT_W-1.
//  Reset mid-wait: returns to RUN next edge regardless of D_MEM_Busy; counters cleared.
// TESTING
//  1 lw x5 in E (RD_E=5,Result_Src=01), RS1_D=5 -> Stall_F=Stall_D=Flush_E=1 one cycle; next cycle all 0.
//  2 RD_M=RD_W=7 both writing, RS1_E=7 -> Forward_A_E=10; RS1_E=0 with RD_M=0 -> 00.
//  3 Mispredict_E=1 with concurrent LU -> Flush_D=Flush_E=1, Stall_F=Stall_D=0; Flush_Count+=1.
//  4 D_MEM_Busy high 3 cycles with Mispredict_E held -> 3 cycles all stalls=1, no flush; 4th cycle flushes.
//  5 MEM_TIMEOUT=4, busy held 10 cycles -> Mem_Timeout=1 after 4th busy cycle, stays after busy drops.
//  6 CNT_W=2, stall 5 cycles -> Stall_Cycles=3; RST_N=0 during ERROR -> state RUN, all counters 0.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard sequencer for the 5-stage RV32i pipeline: forwarding, load-use bubbles,
// redirect flushes, data-memory wait/timeout FSM and saturating perf counters.
module hazard_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             REG_W_En_E,
    input  logic             REG_W_En_M,
    input  logic             REG_W_En_W,
    input  logic [1:0]       Result_Src_Sel_E,
    input  logic             Mispredict_E,
    input  logic             D_MEM_Busy,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic [1:0]       Forward_A_E,
    output logic [1:0]       Forward_B_E,
    output logic             Mem_Timeout,
    output logic [CNT_W-1:0] Stall_Cycles,
    output logic [CNT_W-1:0] Flush_Count
);

    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WW:0] TMO = (WW + 1)'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [WW:0]   wait_nxt;
    logic          load_use;

    assign wait_nxt = {1'b0, wait_cnt} + 1'b1;

    // MEM stage result is younger than WB, so it wins.
    always_comb begin
        Forward_A_E = 2'b00;
        if (RS1_E != 5'd0 && REG_W_En_M && RD_M == RS1_E)
            Forward_A_E = 2'b10;
        else if (RS1_E != 5'd0 && REG_W_En_W && RD_W == RS1_E)
            Forward_A_E = 2'b01;
    end

    always_comb begin
        Forward_B_E = 2'b00;
        if (RS2_E != 5'd0 && REG_W_En_M && RD_M == RS2_E)
            Forward_B_E = 2'b10;
        else if (RS2_E != 5'd0 && REG_W_En_W && RD_W == RS2_E)
            Forward_B_E = 2'b01;
    end

    assign load_use = REG_W_En_E && (Result_Src_Sel_E == 2'b01) &&
                      (RD_E != 5'd0) &&
                      ((RD_E == RS1_D) || (RD_E == RS2_D));

    always_comb begin
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Stall_E = 1'b0;
        Stall_M = 1'b0;
        Flush_D = 1'b0;
        Flush_E = 1'b0;
        if (!RST_N) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (state == ERROR || D_MEM_Busy) begin
            // Freeze everything; E/D hazards are re-evaluated once memory is ready.
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
        end else if (Mispredict_E) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (load_use) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= RUN;
            wait_cnt    <= '0;
            Mem_Timeout <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (D_MEM_Busy) begin
                        if (TMO <= 1) begin
                            state       <= ERROR;
                            Mem_Timeout <= 1'b1;
                        end else begin
                            state    <= MEM_WAIT;
                            wait_cnt <= WW'(1);
                        end
                    end
                end
                MEM_WAIT: begin
                    if (!D_MEM_Busy) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_nxt >= TMO) begin
                        state       <= ERROR;
                        Mem_Timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_nxt[WW-1:0];
                    end
                end
                ERROR: begin
                    Mem_Timeout <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Stall_Cycles <= '0;
            Flush_Count  <= '0;
        end else begin
            if (Stall_F && Stall_Cycles != '1)
                Stall_Cycles <= Stall_Cycles + 1'b1;
            if (Flush_E && Flush_Count != '1)
                Flush_Count <= Flush_Count + 1'b1;
        end
    end

endmodule
